// File: rtl/snn_udp_pkg.sv
// Shared types and constants for the SNN UDP transmit framer.
package snn_udp_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_SPK_LO,
        ST_HDR,
        ST_START,
        ST_WAIT
    } state_t;

    localparam int HDR_LEN = 6;
    localparam logic [7:0] MAGIC_HI = 8'h5A;
    localparam logic [7:0] MAGIC_LO = 8'hA5;

    localparam int OFS_MAGIC_HI = 0;
    localparam int OFS_MAGIC_LO = 1;
    localparam int OFS_STEP_HI  = 2;
    localparam int OFS_STEP_LO  = 3;
    localparam int OFS_CNT_HI   = 4;
    localparam int OFS_CNT_LO   = 5;
    localparam int OFS_SPK      = 6;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] step,
                                            input logic [15:0] cnt);
        logic [7:0] b;
        b = 8'h00;
        case (int'(idx))
            OFS_MAGIC_HI: b = MAGIC_HI;
            OFS_MAGIC_LO: b = MAGIC_LO;
            OFS_STEP_HI:  b = step[15:8];
            OFS_STEP_LO:  b = step[7:0];
            OFS_CNT_HI:   b = cnt[15:8];
            OFS_CNT_LO:   b = cnt[7:0];
            default:      b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/snn_udp_tx_framer.sv
// Packs one timestep of spikes into packet RAM and starts the UDP transmit.
// SNN_TX_SKIP_EMPTY_EN: when defined, an empty timestep sends nothing.
module snn_udp_tx_framer
    import snn_udp_pkg::*;
#(
    parameter int MAX_SPIKES = 256,
    parameter int ADDR_W     = 10
) (
    input  logic              SNN_CLK,
    input  logic              udp_tx_done_clr,
    input  logic              spike_valid,
    input  logic [15:0]       spike_idx,
    output logic              spike_ready,
    input  logic              step_end,
    input  logic [15:0]       step_num,
    output logic              pkt_wr_en,
    output logic [ADDR_W-1:0] pkt_wr_addr,
    output logic [7:0]        pkt_wr_data,
    output logic              car_module_tx,
    output logic [15:0]       car_module_tx_num,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_SPIKES + 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  count, count_d;
    logic              pending, pending_d;
    logic [15:0]       step_q, step_d;
    logic [7:0]        lo_q, lo_d;
    logic [2:0]        hdr_idx, hdr_idx_d;
    logic              ready_d, wr_en_d, tx_d, busy_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;
    logic [15:0]       num_d;
    logic [15:0]       count16;
    logic [ADDR_W-1:0] spk_addr;
    logic              accept;
    logic              skip_empty;

    assign count16  = 16'(count);
    assign spk_addr = ADDR_W'(OFS_SPK) + ADDR_W'({count, 1'b0});
    assign accept   = spike_valid && spike_ready;

`ifdef SNN_TX_SKIP_EMPTY_EN
    assign skip_empty = (count == '0);
`else
    assign skip_empty = 1'b0;
`endif

    always_ff @(posedge SNN_CLK or posedge udp_tx_done_clr) begin
        if (udp_tx_done_clr) begin
            state             <= ST_COLLECT;
            count             <= '0;
            pending           <= 1'b0;
            step_q            <= '0;
            lo_q              <= '0;
            hdr_idx           <= '0;
            spike_ready       <= 1'b1;
            pkt_wr_en         <= 1'b0;
            pkt_wr_addr       <= '0;
            pkt_wr_data       <= '0;
            car_module_tx     <= 1'b0;
            car_module_tx_num <= '0;
            busy              <= 1'b0;
        end else begin
            state             <= state_d;
            count             <= count_d;
            pending           <= pending_d;
            step_q            <= step_d;
            lo_q              <= lo_d;
            hdr_idx           <= hdr_idx_d;
            spike_ready       <= ready_d;
            pkt_wr_en         <= wr_en_d;
            pkt_wr_addr       <= addr_d;
            pkt_wr_data       <= data_d;
            car_module_tx     <= tx_d;
            car_module_tx_num <= num_d;
            busy              <= busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        count_d   = count;
        pending_d = pending;
        step_d    = step_q;
        lo_d      = lo_q;
        hdr_idx_d = hdr_idx;
        wr_en_d   = 1'b0;
        addr_d    = pkt_wr_addr;
        data_d    = pkt_wr_data;
        tx_d      = car_module_tx;
        num_d     = car_module_tx_num;

        case (state)
            ST_COLLECT: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    addr_d  = spk_addr;
                    data_d  = spike_idx[15:8];
                    lo_d    = spike_idx[7:0];
                    state_d = ST_SPK_LO;
                    if (step_end) begin
                        pending_d = 1'b1;
                        step_d    = step_num;
                    end
                end else if (step_end && !skip_empty) begin
                    // Magic byte 0 goes out on the taking edge so the header lands in t+1..t+6.
                    step_d    = step_num;
                    wr_en_d   = 1'b1;
                    addr_d    = '0;
                    data_d    = MAGIC_HI;
                    hdr_idx_d = 3'd1;
                    state_d   = ST_HDR;
                end
            end
            ST_SPK_LO: begin
                wr_en_d = 1'b1;
                addr_d  = spk_addr + ADDR_W'(1);
                data_d  = lo_q;
                count_d = count + CNT_W'(1);
                if (pending || step_end) begin
                    if (!pending) step_d = step_num;
                    pending_d = 1'b0;
                    hdr_idx_d = '0;
                    state_d   = ST_HDR;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HDR: begin
                wr_en_d   = 1'b1;
                addr_d    = ADDR_W'(hdr_idx);
                data_d    = hdr_byte(hdr_idx, step_q, count16);
                hdr_idx_d = hdr_idx + 3'd1;
                if (hdr_idx == 3'(HDR_LEN - 1)) state_d = ST_START;
            end
            ST_START: begin
                tx_d    = 1'b1;
                num_d   = 16'(HDR_LEN) + {count16[14:0], 1'b0};
                state_d = ST_WAIT;
            end
            ST_WAIT: ;
            default: state_d = ST_COLLECT;
        endcase

        ready_d = (state_d == ST_COLLECT) && (count_d < CNT_W'(MAX_SPIKES));
        busy_d  = (state_d != ST_COLLECT);
    end

endmodule

// File: tb/tb_snn_udp_tx_framer.sv
// Directed self-checking bench for snn_udp_tx_framer.
module tb_snn_udp_tx_framer;

    logic        SNN_CLK = 1'b0;
    logic        udp_tx_done_clr = 1'b1;
    logic        spike_valid = 1'b0;
    logic [15:0] spike_idx = '0;
    logic        spike_ready;
    logic        step_end = 1'b0;
    logic [15:0] step_num = '0;
    logic        pkt_wr_en;
    logic [9:0]  pkt_wr_addr;
    logic [7:0]  pkt_wr_data;
    logic        car_module_tx;
    logic [15:0] car_module_tx_num;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] ram [1024];
    int wr_total = 0;
    int hi_total = 0;
    int tx_total = 0;

    snn_udp_tx_framer dut (
        .SNN_CLK(SNN_CLK), .udp_tx_done_clr(udp_tx_done_clr),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
        .step_end(step_end), .step_num(step_num),
        .pkt_wr_en(pkt_wr_en), .pkt_wr_addr(pkt_wr_addr), .pkt_wr_data(pkt_wr_data),
        .car_module_tx(car_module_tx), .car_module_tx_num(car_module_tx_num), .busy(busy)
    );

    always #5 SNN_CLK = ~SNN_CLK;

    // Packet RAM model and activity counters, sampled mid-cycle.
    always @(negedge SNN_CLK) begin
        if (pkt_wr_en) begin
            ram[pkt_wr_addr] = pkt_wr_data;
            wr_total++;
            if (pkt_wr_addr > 10'd517) hi_total++;
        end
        if (car_module_tx) tx_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step_and_wait(input logic [15:0] s, output int k);
        @(negedge SNN_CLK); step_end = 1'b1; step_num = s;
        @(negedge SNN_CLK); step_end = 1'b0; k = 0;
        while (!car_module_tx && k < 40) begin @(negedge SNN_CLK); k++; end
    endtask

    task automatic wait_tx(output int k);
        k = 0;
        while (!car_module_tx && k < 40) begin @(negedge SNN_CLK); k++; end
    endtask

    task automatic send_spike(input logic [15:0] v);
        int n;
        n = 0;
        @(negedge SNN_CLK); spike_valid = 1'b1; spike_idx = v;
        while (!spike_ready && n < 20) begin @(negedge SNN_CLK); n++; end
        chk("spike_handshake", 32'(n < 20), 32'd1);
        @(negedge SNN_CLK); spike_valid = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge SNN_CLK); udp_tx_done_clr = 1'b1;
        @(negedge SNN_CLK); udp_tx_done_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp1 [12];
        int k, n, wr0, hi0, tx0;
        exp1 = '{8'h5A, 8'hA5, 8'h00, 8'h07, 8'h00, 8'h03, 8'h00, 8'h12, 8'h03, 8'h45, 8'h00, 8'hFF};

        // Reset state
        @(negedge SNN_CLK); @(negedge SNN_CLK);
        chk("rst_ready", 32'(spike_ready), 32'd1);
        chk("rst_wr_en", 32'(pkt_wr_en), 32'd0);
        chk("rst_addr", 32'(pkt_wr_addr), 32'd0);
        chk("rst_data", 32'(pkt_wr_data), 32'd0);
        chk("rst_tx", 32'(car_module_tx), 32'd0);
        chk("rst_num", 32'(car_module_tx_num), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        udp_tx_done_clr = 1'b0;

        // Three spikes then step 7
        send_spike(16'h0012);
        send_spike(16'h0345);
        send_spike(16'h00FF);
        step_and_wait(16'h0007, k);
        chk("t1_tx_latency", 32'(k), 32'd6);
        chk("t1_num", 32'(car_module_tx_num), 32'd12);
        for (int i = 0; i < 12; i++) chk($sformatf("t1_ram%0d", i), 32'(ram[i]), 32'(exp1[i]));
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready_wait", 32'(spike_ready), 32'd0);

        // step_end in WAIT is ignored
        @(negedge SNN_CLK); step_end = 1'b1; step_num = 16'h0099;
        @(negedge SNN_CLK); step_end = 1'b0;
        @(negedge SNN_CLK);
        chk("wait_hold_tx", 32'(car_module_tx), 32'd1);
        chk("wait_hold_num", 32'(car_module_tx_num), 32'd12);

        // Done pulse clears asynchronously
        @(negedge SNN_CLK); udp_tx_done_clr = 1'b1;
        #1;
        chk("done_tx", 32'(car_module_tx), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_num", 32'(car_module_tx_num), 32'd0);
        @(negedge SNN_CLK); udp_tx_done_clr = 1'b0;
        spike_valid = 1'b1; spike_idx = 16'hABCD;
        @(negedge SNN_CLK); spike_valid = 1'b0;
        chk("post_done_hi_en", 32'(pkt_wr_en), 32'd1);
        chk("post_done_hi_addr", 32'(pkt_wr_addr), 32'd6);
        chk("post_done_hi_data", 32'(pkt_wr_data), 32'hAB);
        @(negedge SNN_CLK);
        chk("post_done_lo_addr", 32'(pkt_wr_addr), 32'd7);
        chk("post_done_lo_data", 32'(pkt_wr_data), 32'hCD);
        done_pulse();

        // Spike and step_end in the same cycle
        @(negedge SNN_CLK);
        spike_valid = 1'b1; spike_idx = 16'h0001; step_end = 1'b1; step_num = 16'h0002;
        @(negedge SNN_CLK); spike_valid = 1'b0; step_end = 1'b0;
        wait_tx(k);
        chk("t2_tx_seen", 32'(car_module_tx), 32'd1);
        chk("t2_num", 32'(car_module_tx_num), 32'd8);
        chk("t2_step_lo", 32'(ram[3]), 32'h02);
        chk("t2_cnt_hi", 32'(ram[4]), 32'h00);
        chk("t2_cnt_lo", 32'(ram[5]), 32'h01);
        chk("t2_spk_hi", 32'(ram[6]), 32'h00);
        chk("t2_spk_lo", 32'(ram[7]), 32'h01);
        done_pulse();

        // Saturate at MAX_SPIKES
        wr0 = wr_total; hi0 = hi_total; n = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge SNN_CLK);
            spike_idx = 16'h1100 + 16'(n);
            spike_valid = 1'b1;
            if (spike_ready) n++;
        end
        @(negedge SNN_CLK);
        chk("t3_accepted", 32'(n), 32'd256);
        chk("t3_ready_low", 32'(spike_ready), 32'd0);
        spike_valid = 1'b0;
        step_and_wait(16'h0100, k);
        chk("t3_num", 32'(car_module_tx_num), 32'd518);
        chk("t3_cnt_hi", 32'(ram[4]), 32'h01);
        chk("t3_cnt_lo", 32'(ram[5]), 32'h00);
        chk("t3_last_hi", 32'(ram[516]), 32'h11);
        chk("t3_last_lo", 32'(ram[517]), 32'hFF);
        chk("t3_writes", 32'(wr_total - wr0), 32'd518);
        chk("t3_beyond_517", 32'(hi_total - hi0), 32'd0);
        done_pulse();

        // Reset while writing the header
        send_spike(16'h0042);
        @(negedge SNN_CLK); step_end = 1'b1; step_num = 16'h0005;
        @(negedge SNN_CLK); step_end = 1'b0;
        @(negedge SNN_CLK);
        tx0 = tx_total;
        done_pulse();
        repeat (15) @(negedge SNN_CLK);
        chk("t4_no_tx", 32'(tx_total - tx0), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Empty step afterwards
        wr0 = wr_total; tx0 = tx_total;
`ifdef SNN_TX_SKIP_EMPTY_EN
        @(negedge SNN_CLK); step_end = 1'b1; step_num = 16'h0009;
        @(negedge SNN_CLK); step_end = 1'b0;
        repeat (20) @(negedge SNN_CLK);
        chk("t5_no_tx", 32'(tx_total - tx0), 32'd0);
        chk("t5_no_writes", 32'(wr_total - wr0), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(spike_ready), 32'd1);
`else
        step_and_wait(16'h0009, k);
        chk("t5_latency", 32'(k), 32'd6);
        chk("t5_num", 32'(car_module_tx_num), 32'd6);
        chk("t5_writes", 32'(wr_total - wr0), 32'd6);
        chk("t5_step_lo", 32'(ram[3]), 32'h09);
        chk("t5_cnt_lo", 32'(ram[5]), 32'h00);
`endif
        done_pulse();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
